// File: rtl/image_rotation.sv
// APB-programmed AHB DMA engine that rotates an 8-bpp row-major image by 0/90/180/270 degrees.
// Each destination pixel costs one word read at the source and one byte write at the destination.
module image_rotation (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic [31:0] I_REG_PADDR,
    input  logic [31:0] I_REG_PWDATA,
    input  logic        I_REG_PSEL,
    input  logic        I_REG_PENABLE,
    input  logic        I_REG_PWRITE,
    output logic [31:0] O_REG_PRDATA,
    input  logic [31:0] I_DMA_HRDATA,
    input  logic        I_DMA_HGRANT,
    input  logic        I_DMA_HREADY,
    output logic [31:0] O_DMA_HADDR,
    output logic [31:0] O_DMA_HWDATA,
    output logic [1:0]  O_DMA_HTRANS,
    output logic [2:0]  O_DMA_HSIZE,
    output logic [2:0]  O_DMA_HBURST,
    output logic        O_DMA_HBUSREQ,
    output logic        O_DMA_HWRITE,
    output logic        O_INTR_DONE
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RA, S_RD, S_WA, S_WD, S_DONE} state_t;
    state_t state;

    logic [31:0] src, dst, hgt, wid;
    logic [1:0]  mode;
    logic        dir, intr_mask, done;
    logic [7:0]  bef_mask, aft_mask;

    logic [31:0] j_src, j_dst;
    logic [15:0] j_h, j_w, j_nh, j_nw, row, col, sr, sc;
    logic [1:0]  j_rot, rot;
    logic [7:0]  j_mask, pix, lane_byte;
    logic        last;
    logic [31:0] sa, da;
    logic [15:0] nh, nw;

    logic [7:0]  addr;
    logic        apb_wr, wr_start, wr_soft, wr_clr;
    logic        addr_unused;

    assign addr        = I_REG_PADDR[7:0];
    assign addr_unused = ^I_REG_PADDR[31:8];
    assign apb_wr      = I_REG_PSEL & I_REG_PENABLE & I_REG_PWRITE;
    assign wr_start    = apb_wr && (addr == 8'h20) && I_REG_PWDATA[0];
    assign wr_soft     = apb_wr && (addr == 8'h24) && I_REG_PWDATA[0];
    assign wr_clr      = apb_wr && (addr == 8'h34) && I_REG_PWDATA[0];

    // Counter-clockwise by MODE is clockwise by (4-MODE) mod 4.
    assign rot = dir ? mode : 2'd0 - mode;
    assign nh  = rot[0] ? wid[15:0] : hgt[15:0];
    assign nw  = rot[0] ? hgt[15:0] : wid[15:0];

    assign O_DMA_HBURST = 3'b000;
    assign O_INTR_DONE  = done & ~intr_mask;

    always_comb begin
        O_REG_PRDATA = '0;
        if (I_REG_PSEL && !I_REG_PWRITE) begin
            case (addr)
                8'h00: O_REG_PRDATA = src;
                8'h04: O_REG_PRDATA = dst;
                8'h08: O_REG_PRDATA = hgt;
                8'h0C: O_REG_PRDATA = wid;
                8'h10: O_REG_PRDATA = {16'h0, nh};
                8'h14: O_REG_PRDATA = {16'h0, nw};
                8'h18: O_REG_PRDATA = {30'h0, mode};
                8'h1C: O_REG_PRDATA = {31'h0, dir};
                8'h20: O_REG_PRDATA = {31'h0, state != S_IDLE};
                8'h28: O_REG_PRDATA = {31'h0, intr_mask};
                8'h2C: O_REG_PRDATA = {24'h0, bef_mask};
                8'h30: O_REG_PRDATA = {24'h0, aft_mask};
                8'h34: O_REG_PRDATA = {31'h0, done};
                default: O_REG_PRDATA = '0;
            endcase
        end
    end

    // Source coordinate of the destination pixel currently addressed by (row, col).
    always_comb begin
        case (j_rot)
            2'd0: begin sr = row;                    sc = col;                    end
            2'd1: begin sr = j_h - 16'd1 - col;      sc = row;                    end
            2'd2: begin sr = j_h - 16'd1 - row;      sc = j_w - 16'd1 - col;      end
            default: begin sr = col;                 sc = j_w - 16'd1 - row;      end
        endcase
        sa = j_src + ({16'h0, sr} * {16'h0, j_w}) + {16'h0, sc};
        da = j_dst + ({16'h0, row} * {16'h0, j_nw}) + {16'h0, col};
        lane_byte = I_DMA_HRDATA[{sa[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            src       <= '0;
            dst       <= '0;
            hgt       <= '0;
            wid       <= '0;
            mode      <= '0;
            dir       <= 1'b0;
            intr_mask <= 1'b0;
            bef_mask  <= '1;
            aft_mask  <= '1;
        end else if (apb_wr) begin
            case (addr)
                8'h00: src       <= I_REG_PWDATA;
                8'h04: dst       <= I_REG_PWDATA;
                8'h08: hgt       <= I_REG_PWDATA;
                8'h0C: wid       <= I_REG_PWDATA;
                8'h18: mode      <= I_REG_PWDATA[1:0];
                8'h1C: dir       <= I_REG_PWDATA[0];
                8'h28: intr_mask <= I_REG_PWDATA[0];
                8'h2C: bef_mask  <= I_REG_PWDATA[7:0];
                8'h30: aft_mask  <= I_REG_PWDATA[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            state         <= S_IDLE;
            done          <= 1'b0;
            O_DMA_HADDR   <= '0;
            O_DMA_HWDATA  <= '0;
            O_DMA_HTRANS  <= '0;
            O_DMA_HSIZE   <= '0;
            O_DMA_HBUSREQ <= 1'b0;
            O_DMA_HWRITE  <= 1'b0;
            j_src  <= '0;
            j_dst  <= '0;
            j_h    <= '0;
            j_w    <= '0;
            j_nh   <= '0;
            j_nw   <= '0;
            j_rot  <= '0;
            j_mask <= '0;
            row    <= '0;
            col    <= '0;
            last   <= 1'b0;
            pix    <= '0;
        end else begin
            // A clear is overridden by the DONE-state set further down.
            if (wr_clr)
                done <= 1'b0;
            if (wr_soft) begin
                state         <= S_IDLE;
                O_DMA_HBUSREQ <= 1'b0;
                O_DMA_HTRANS  <= 2'b00;
                done          <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (wr_start) begin
                        j_src  <= src;
                        j_dst  <= dst;
                        j_h    <= hgt[15:0];
                        j_w    <= wid[15:0];
                        j_nh   <= nh;
                        j_nw   <= nw;
                        j_rot  <= rot;
                        j_mask <= bef_mask & aft_mask;
                        row    <= '0;
                        col    <= '0;
                        if (hgt[15:0] == 16'h0 || wid[15:0] == 16'h0) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_REQ;
                            O_DMA_HBUSREQ <= 1'b1;
                        end
                    end
                    S_REQ: if (I_DMA_HGRANT && I_DMA_HREADY) begin
                        state        <= S_RA;
                        O_DMA_HTRANS <= 2'b10;
                        O_DMA_HADDR  <= {sa[31:2], 2'b00};
                        O_DMA_HSIZE  <= 3'd2;
                        O_DMA_HWRITE <= 1'b0;
                    end
                    S_RA: begin
                        if (!I_DMA_HGRANT) begin
                            state        <= S_REQ;
                            O_DMA_HTRANS <= 2'b00;
                        end else if (I_DMA_HREADY) begin
                            state        <= S_RD;
                            O_DMA_HTRANS <= 2'b00;
                        end
                    end
                    S_RD: if (I_DMA_HREADY) begin
                        pix          <= lane_byte & j_mask;
                        state        <= S_WA;
                        O_DMA_HTRANS <= 2'b10;
                        O_DMA_HADDR  <= da;
                        O_DMA_HSIZE  <= 3'd0;
                        O_DMA_HWRITE <= 1'b1;
                    end
                    // Counters advance here so sa already points at the next pixel in WD.
                    S_WA: if (I_DMA_HREADY) begin
                        state        <= S_WD;
                        O_DMA_HTRANS <= 2'b00;
                        O_DMA_HWDATA <= {4{pix}};
                        last         <= (row == j_nh - 16'd1) && (col == j_nw - 16'd1);
                        if (col == j_nw - 16'd1) begin
                            col <= '0;
                            row <= row + 16'd1;
                        end else begin
                            col <= col + 16'd1;
                        end
                    end
                    S_WD: if (I_DMA_HREADY) begin
                        if (last) begin
                            state         <= S_DONE;
                            O_DMA_HBUSREQ <= 1'b0;
                        end else begin
                            state        <= S_RA;
                            O_DMA_HTRANS <= 2'b10;
                            O_DMA_HADDR  <= {sa[31:2], 2'b00};
                            O_DMA_HSIZE  <= 3'd2;
                            O_DMA_HWRITE <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        done          <= 1'b1;
                        O_DMA_HBUSREQ <= 1'b0;
                        state         <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_image_rotation.sv
// Randomized bench for image_rotation: AHB slave model with wait states, APB host tasks and
// a 2-D array rotation reference model.
module tb_image_rotation;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, psel, penable, pwrite, hgrant, hready, hbusreq, hwrite, intr;
    logic [31:0] paddr, pwdata, prdata, hrdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    image_rotation dut (
        .I_HCLK(clk), .I_HRESET(rst),
        .I_REG_PADDR(paddr), .I_REG_PWDATA(pwdata), .I_REG_PSEL(psel),
        .I_REG_PENABLE(penable), .I_REG_PWRITE(pwrite), .O_REG_PRDATA(prdata),
        .I_DMA_HRDATA(hrdata), .I_DMA_HGRANT(hgrant), .I_DMA_HREADY(hready),
        .O_DMA_HADDR(haddr), .O_DMA_HWDATA(hwdata), .O_DMA_HTRANS(htrans),
        .O_DMA_HSIZE(hsize), .O_DMA_HBURST(hburst), .O_DMA_HBUSREQ(hbusreq),
        .O_DMA_HWRITE(hwrite), .O_INTR_DONE(intr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- AHB slave model (4 KB, word-addressed) ----------------
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [2:0] size; } xfer_t;
    logic [31:0] mem [0:1023];
    xfer_t       wr_q[$], rd_q[$];
    logic        dp_act, dp_write;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    int unsigned dp_cnt;
    int unsigned ws_fixed = 0;
    bit          ws_rand = 1'b0;
    int unsigned nonseq_cnt = 0;
    int unsigned job_base = 0;

    assign hready = !(dp_act && dp_cnt != 0);
    assign hrdata = dp_act ? mem[dp_addr[11:2]] : 32'h0;

    always @(posedge clk or posedge rst) begin : slave
        xfer_t x;
        if (rst) begin
            dp_act <= 1'b0; dp_write <= 1'b0; dp_addr <= '0; dp_size <= '0; dp_cnt <= 0;
        end else begin
            if (dp_act && hready) begin
                dp_act <= 1'b0;
                x.addr = dp_addr; x.size = dp_size;
                x.data = dp_write ? hwdata : hrdata;
                if (dp_write) wr_q.push_back(x);
                else          rd_q.push_back(x);
            end else if (dp_act) begin
                dp_cnt <= dp_cnt - 1;
            end
            if (htrans == 2'b10 && hready) begin
                dp_act <= 1'b1; dp_addr <= haddr; dp_write <= hwrite; dp_size <= hsize;
                dp_cnt <= ws_rand ? $urandom_range(2, 0) : ws_fixed;
                nonseq_cnt <= nonseq_cnt + 1;
            end
        end
    end

    // ---------------- APB host ----------------
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); psel = 1; pwrite = 1; penable = 0; paddr = {24'h0, a}; pwdata = d;
        @(negedge clk); penable = 1;
        @(negedge clk); psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk); psel = 1; pwrite = 0; penable = 0; paddr = {24'h0, a};
        @(negedge clk); penable = 1;
        #1 d = prdata;
        @(negedge clk); psel = 0; penable = 0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        apb_read(a, v);
        check(tag, v, exp);
    endtask

    // ---------------- Reference model: rotate a 2-D image array ----------------
    logic [7:0]  img [0:15][0:15];
    int unsigned idx [0:15][0:15];
    int unsigned mh, mw;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] wd;
        wd = mem[a[11:2]];
        return wd[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic build_model(input logic [31:0] src, input int unsigned h, w, mode, dir);
        logic [7:0]  ti [0:15][0:15];
        int unsigned tx [0:15][0:15];
        int unsigned rot, t;
        mh = h; mw = w;
        for (int unsigned r = 0; r < h; r++)
            for (int unsigned c = 0; c < w; c++) begin
                idx[r][c] = r * w + c;
                img[r][c] = byte_at(src + idx[r][c]);
            end
        rot = dir ? mode : (4 - mode) % 4;
        for (int unsigned k = 0; k < rot; k++) begin
            for (int unsigned i = 0; i < mw; i++)
                for (int unsigned j = 0; j < mh; j++) begin
                    ti[i][j] = img[mh - 1 - j][i];
                    tx[i][j] = idx[mh - 1 - j][i];
                end
            img = ti; idx = tx;
            t = mh; mh = mw; mw = t;
        end
    endtask

    task automatic program_and_start(input string tag, input logic [31:0] src, dst,
                                     input int unsigned h, w, input logic [1:0] mode,
                                     input logic dir, input logic [7:0] bm, am,
                                     input logic imask, input bit disturb, input int unsigned gdelay);
        build_model(src, h, w, mode, dir);
        apb_write(8'h00, src);  apb_write(8'h04, dst);
        apb_write(8'h08, h);    apb_write(8'h0C, w);
        apb_write(8'h18, {30'h0, mode}); apb_write(8'h1C, {31'h0, dir});
        apb_write(8'h2C, {24'h0, bm});   apb_write(8'h30, {24'h0, am});
        apb_write(8'h28, {31'h0, imask}); apb_write(8'h34, 32'h1);
        check_reg({tag, " nh"}, 8'h10, mh);
        check_reg({tag, " nw"}, 8'h14, mw);
        wr_q.delete(); rd_q.delete();
        job_base = nonseq_cnt;
        if (gdelay > 0) hgrant = 1'b0;
        apb_write(8'h20, 32'h1);
        for (int unsigned i = 0; i < gdelay; i++) begin
            @(negedge clk);
            check({tag, " htrans w/o grant"}, {30'h0, htrans}, 32'h0);
            check({tag, " busreq w/o grant"}, {31'h0, hbusreq}, 32'h1);
        end
        hgrant = 1'b1;
        if (disturb) begin
            apb_write(8'h20, 32'h1);
            apb_write(8'h00, $urandom);
            apb_write(8'h08, $urandom_range(9, 1));
            apb_write(8'h2C, $urandom);
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        int unsigned n;
        v = 32'h0; n = 0;
        while (v !== 32'h1 && n < 1500) begin
            apb_read(8'h34, v);
            n++;
        end
        check({tag, " done flag"}, v, 32'h1);
    endtask

    task automatic compare(input string tag, input logic [31:0] src, dst,
                           input logic [7:0] mask, input logic imask);
        int unsigned k;
        check({tag, " write count"}, wr_q.size(), mh * mw);
        check({tag, " read count"}, rd_q.size(), mh * mw);
        check({tag, " addr phases"}, nonseq_cnt - job_base, 2 * mh * mw);
        for (int unsigned r = 0; r < mh; r++)
            for (int unsigned c = 0; c < mw; c++) begin
                k = r * mw + c;
                if (k < wr_q.size()) begin
                    check({tag, " wr addr"}, wr_q[k].addr, dst + k);
                    check({tag, " wr data"}, wr_q[k].data, {4{img[r][c] & mask}});
                    check({tag, " wr size"}, {29'h0, wr_q[k].size}, 32'h0);
                end
                if (k < rd_q.size()) begin
                    check({tag, " rd addr"}, rd_q[k].addr, (src + idx[r][c]) & 32'hFFFF_FFFC);
                    check({tag, " rd size"}, {29'h0, rd_q[k].size}, 32'h2);
                end
            end
        check({tag, " intr"}, {31'h0, intr}, {31'h0, ~imask});
    endtask

    task automatic run_job(input string tag, input logic [31:0] src, dst,
                           input int unsigned h, w, input logic [1:0] mode, input logic dir,
                           input logic [7:0] bm, am, input logic imask, input bit disturb,
                           input int unsigned gdelay);
        program_and_start(tag, src, dst, h, w, mode, dir, bm, am, imask, disturb, gdelay);
        wait_done(tag);
        compare(tag, src, dst, bm & am, imask);
    endtask

    task automatic fill_mem();
        for (int unsigned i = 0; i < 1024; i++) mem[i] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  e_cw [0:5];
        logic [7:0]  e_180 [0:5];
        logic [7:0]  e_ccw [0:5];
        int unsigned n, base, h, w;
        e_cw  = '{8'd4, 8'd1, 8'd5, 8'd2, 8'd6, 8'd3};
        e_180 = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        e_ccw = '{8'd3, 8'd6, 8'd2, 8'd5, 8'd1, 8'd4};
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; hgrant = 1;
        fill_mem();
        repeat (3) @(negedge clk);
        check("reset busreq", {31'h0, hbusreq}, 32'h0);
        check("reset htrans", {30'h0, htrans}, 32'h0);
        check("reset haddr", haddr, 32'h0);
        check("reset hwdata", hwdata, 32'h0);
        check("reset hwrite/hsize/hburst", {25'h0, hwrite, hsize, hburst}, 32'h0);
        check("reset intr", {31'h0, intr}, 32'h0);
        rst = 0;
        check_reg("reset bef_mask", 8'h2C, 32'hFF);
        check_reg("reset aft_mask", 8'h30, 32'hFF);
        check_reg("reset src", 8'h00, 32'h0);
        check_reg("reset start", 8'h20, 32'h0);

        // 1x1, 90 cw
        mem[32'h100 >> 2] = 32'h44332211;
        run_job("1x1", 32'h100, 32'h200, 1, 1, 2'd1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        if (wr_q.size() > 0) check("1x1 hwdata", wr_q[0].data, 32'h11111111);
        if (rd_q.size() > 0) check("1x1 rd addr", rd_q[0].addr, 32'h100);
        check_reg("1x1 nh", 8'h10, 32'h1);

        // 2x3 image holding 1..6
        mem[32'h300 >> 2] = 32'h04030201;
        mem[32'h304 >> 2] = (mem[32'h304 >> 2] & 32'hFFFF0000) | 32'h0605;
        run_job("2x3 cw", 32'h300, 32'h900, 2, 3, 2'd1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        for (int unsigned i = 0; i < 6; i++)
            if (i < wr_q.size()) check("2x3 cw byte", {24'h0, wr_q[i].data[7:0]}, {24'h0, e_cw[i]});
        run_job("2x3 180", 32'h300, 32'h900, 2, 3, 2'd2, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        for (int unsigned i = 0; i < 6; i++)
            if (i < wr_q.size()) check("2x3 180 byte", {24'h0, wr_q[i].data[7:0]}, {24'h0, e_180[i]});
        run_job("2x3 ccw", 32'h300, 32'h900, 2, 3, 2'd1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        for (int unsigned i = 0; i < 6; i++)
            if (i < wr_q.size()) check("2x3 ccw byte", {24'h0, wr_q[i].data[7:0]}, {24'h0, e_ccw[i]});

        // Late grant and 3 wait states in every data phase
        ws_fixed = 3;
        run_job("grant/wait", 32'h123, 32'hA05, 3, 4, 2'd3, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 5);
        ws_fixed = 0;

        // Masked interrupt, then clear
        run_job("intr mask", 32'h040, 32'h840, 2, 2, 2'd0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        check_reg("intr mask raw done", 8'h34, 32'h1);
        apb_write(8'h34, 32'h1);
        check_reg("intr clr raw done", 8'h34, 32'h0);

        // Soft reset after two writes
        fill_mem();
        program_and_start("srst", 32'h010, 32'h810, 6, 6, 2'd2, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        n = 0;
        while (wr_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
        check("srst writes before", wr_q.size(), 2);
        apb_write(8'h24, 32'h1);
        check("srst busreq", {31'h0, hbusreq}, 32'h0);
        check("srst htrans", {30'h0, htrans}, 32'h0);
        base = nonseq_cnt;
        check_reg("srst start", 8'h20, 32'h0);
        repeat (20) @(negedge clk);
        check("srst no traffic", nonseq_cnt - base, 32'h0);
        check_reg("srst done", 8'h34, 32'h0);
        run_job("after srst", 32'h020, 32'h820, 4, 5, 2'd1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);

        // Byte masking
        mem[32'h500 >> 2] = 32'h0000AB00;
        run_job("bef mask", 32'h501, 32'hC00, 1, 1, 2'd0, 1'b0, 8'h0F, 8'hFF, 1'b0, 1'b0, 0);
        if (wr_q.size() > 0) check("bef mask data", wr_q[0].data, 32'h0B0B0B0B);

        // Zero height
        run_job("h0", 32'h100, 32'h900, 0, 4, 2'd1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);

        // Hard reset mid-job
        program_and_start("hrst", 32'h030, 32'h830, 5, 5, 2'd3, 1'b0, 8'h3C, 8'hF0, 1'b0, 1'b0, 0);
        repeat (12) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("hrst busreq", {31'h0, hbusreq}, 32'h0);
        check("hrst htrans", {30'h0, htrans}, 32'h0);
        check("hrst haddr", haddr, 32'h0);
        rst = 0;
        check_reg("hrst bef_mask", 8'h2C, 32'hFF);
        check_reg("hrst src", 8'h00, 32'h0);
        check_reg("hrst start", 8'h20, 32'h0);

        // Randomized jobs
        ws_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fill_mem();
            h = $urandom_range(7, 1);
            w = $urandom_range(7, 1);
            run_job($sformatf("rnd%0d", i), $urandom_range(32'h6C0, 0), 32'h800 + $urandom_range(32'h6C0, 0),
                    h, w, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    ($urandom_range(1, 0) != 0) ? 8'($urandom) : 8'hFF,
                    ($urandom_range(1, 0) != 0) ? 8'($urandom) : 8'hFF,
                    1'b0, (h * w >= 4) && ($urandom_range(1, 0) != 0), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
